hazard_ctrl: RTL and testbench

//  Pipeline sequencer between id_stage and EX. Scoreboards pending register-file writes and

---
 rtl/riscv_pipe_pkg.sv | 13 +
 rtl/hazard_scoreboard.sv | 74 +++++++
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: sequencer state encoding and the bubble instruction.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } pipe_state_t;

    // addi x0, x0, 0 -- what ID/EX is loaded with whenever bubble_ex is high
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending register-write scoreboard: tracks in-flight writers, flags RAW/WAW
// hazards against the ID instruction and reports when the writer table is full.
module hazard_scoreboard
    import riscv_pipe_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int REG_SEL     = $clog2(NUM_REGS),
    parameter int MAX_PENDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_SEL-1:0]  id_rs1,
    input  logic [REG_SEL-1:0]  id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_SEL-1:0]  id_rd,
    input  logic                id_write_reg,
    input  logic                issue,
    input  logic                wb_valid,
    input  logic [REG_SEL-1:0]  wb_rd,
    output logic                hazard,
    output logic                full,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [3:0]          pending_cnt,
    output logic                err_wb_idle
);

    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                do_set;
    logic                do_clr;
    logic                wb_idle;

    // RAW on either source, WAW on the destination; x0 never counts as busy
    always_comb begin
        hazard = 1'b0;
        if (id_use_rs1 && (id_rs1 != '0) && busy_mask[id_rs1]) hazard = 1'b1;
        if (id_use_rs2 && (id_rs2 != '0) && busy_mask[id_rs2]) hazard = 1'b1;
        if (id_write_reg && (id_rd != '0) && busy_mask[id_rd]) hazard = 1'b1;
    end

    assign full = (pending_cnt == 4'(MAX_PENDING)) && id_write_reg;

    // One-hot set/clear vectors; applying the set after the clear lets a new
    // writer win over a retiring one on the same register
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue && id_write_reg && (id_rd != '0)) set_vec[id_rd] = 1'b1;
        if (wb_valid && (wb_rd != '0) && busy_mask[wb_rd]) clr_vec[wb_rd] = 1'b1;
    end

    assign do_set  = |set_vec;
    assign do_clr  = |clr_vec;
    assign wb_idle = wb_valid && (wb_rd != '0) && !busy_mask[wb_rd];

    // Scoreboard state, bounded writer count and sticky idle-writeback error
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_mask   <= '0;
            pending_cnt <= '0;
            err_wb_idle <= 1'b0;
        end else begin
            busy_mask <= (busy_mask & ~clr_vec) | set_vec;
            unique case ({do_set, do_clr})
                2'b10: if (pending_cnt < 4'(MAX_PENDING)) pending_cnt <= pending_cnt + 4'd1;
                2'b01: if (pending_cnt != 4'd0) pending_cnt <= pending_cnt - 4'd1;
                default: pending_cnt <= pending_cnt;
            endcase
            if (wb_idle) err_wb_idle <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer between ID and EX: issue/stall/bubble decisions, redirect
// flush sequencing, fence drain and a saturating stall-cycle counter.
//
//  state | meaning
//  RUN   | normal issue; stalls on hazard, full table, back-pressure, fence
//  FLUSH | IF/ID invalidated for FLUSH_CYCLES cycles after a redirect
//  DRAIN | fence held in ID until every pending write has retired
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int REG_SEL      = $clog2(NUM_REGS),
    parameter int MAX_PENDING  = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_SEL-1:0]  id_rs1,
    input  logic [REG_SEL-1:0]  id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_SEL-1:0]  id_rd,
    input  logic                id_write_reg,
    input  logic                id_fence,
    input  logic                ex_ready,
    input  logic                wb_valid,
    input  logic [REG_SEL-1:0]  wb_rd,
    input  logic                flush_req,
    output logic                issue,
    output logic                stall_if_id,
    output logic                bubble_ex,
    output logic                flush_if_id,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [3:0]          pending_cnt,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic                err_wb_idle
);

    pipe_state_t state;
    pipe_state_t state_nxt;
    logic [2:0]  flush_cnt;
    logic        hazard;
    logic        full;

    hazard_scoreboard #(
        .NUM_REGS    (NUM_REGS),
        .REG_SEL     (REG_SEL),
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_write_reg (id_write_reg),
        .issue        (issue),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .hazard       (hazard),
        .full         (full),
        .busy_mask    (busy_mask),
        .pending_cnt  (pending_cnt),
        .err_wb_idle  (err_wb_idle)
    );

    // State register; reset aborts any flush or drain in progress
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_nxt;
    end

    // Next state; a redirect overrides everything in every state
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (flush_req)                  state_nxt = ST_FLUSH;
                else if (id_valid && id_fence)  state_nxt = ST_DRAIN;
            end
            ST_FLUSH: begin
                if (flush_req)                  state_nxt = ST_FLUSH;
                else if (flush_cnt <= 3'd1)     state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                if (flush_req)                  state_nxt = ST_FLUSH;
                else if (pending_cnt == 4'd0)   state_nxt = ST_RUN;
            end
            default:                            state_nxt = ST_RUN;
        endcase
    end

    // Pipeline control outputs; forced quiet while reset is asserted
    always_comb begin
        issue       = 1'b0;
        stall_if_id = 1'b0;
        bubble_ex   = 1'b1;
        flush_if_id = 1'b0;
        unique case (state)
            ST_RUN: begin
                issue       = id_valid && ex_ready && !hazard && !full && !flush_req && !id_fence;
                stall_if_id = id_valid && !issue;
                bubble_ex   = !issue;
            end
            ST_FLUSH: begin
                flush_if_id = 1'b1;
            end
            ST_DRAIN: begin
                issue       = (pending_cnt == 4'd0) && !flush_req;
                stall_if_id = !issue;
                bubble_ex   = !issue;
            end
            default: begin
                bubble_ex   = 1'b1;
            end
        endcase
        if (!rst) begin
            issue       = 1'b0;
            stall_if_id = 1'b0;
            bubble_ex   = 1'b0;
            flush_if_id = 1'b0;
        end
    end

    // Flush length counter; every redirect reloads it
    always_ff @(posedge clk) begin
        if (!rst)                                      flush_cnt <= 3'd0;
        else if (flush_req)                            flush_cnt <= 3'(FLUSH_CYCLES);
        else if (state == ST_FLUSH && flush_cnt != 0)  flush_cnt <= flush_cnt - 3'd1;
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (!rst)                                      stall_cycles <= '0;
        else if (stall_if_id && (stall_cycles != '1))  stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes the hand-computed expected
// response of each cycle; a negedge monitor pops and compares.
module tb_hazard_ctrl;
    import riscv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs1, id_use_rs2, id_write_reg, id_fence, ex_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        wb_valid, flush_req;
    logic        issue, stall_if_id, bubble_ex, flush_if_id, err_wb_idle;
    logic [31:0] busy_mask;
    logic [3:0]  pending_cnt;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       nm;
        logic [3:0]  outs;   // {issue, stall_if_id, bubble_ex, flush_if_id}
        bit          chk_st;
        logic [31:0] busy;
        logic [3:0]  cnt;
        logic        err;
        bit          chk_sc;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_write_reg (id_write_reg),
        .id_fence     (id_fence),
        .ex_ready     (ex_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush_req    (flush_req),
        .issue        (issue),
        .stall_if_id  (stall_if_id),
        .bubble_ex    (bubble_ex),
        .flush_if_id  (flush_if_id),
        .busy_mask    (busy_mask),
        .pending_cnt  (pending_cnt),
        .stall_cycles (stall_cycles),
        .err_wb_idle  (err_wb_idle)
    );

    always #5 clk = ~clk;

    // Monitor: compare the DUT against the expectation queued for this cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [3:0] got;
            e   = exp_q.pop_front();
            got = {issue, stall_if_id, bubble_ex, flush_if_id};
            n_checks++;
            if (got !== e.outs) begin
                n_fail++;
                $display("FAIL %s outs{iss,stl,bub,fl}: got %b expected %b", e.nm, got, e.outs);
            end
            if (e.chk_st) begin
                n_checks++;
                if (busy_mask !== e.busy || pending_cnt !== e.cnt || err_wb_idle !== e.err) begin
                    n_fail++;
                    $display("FAIL %s state: got busy=%h cnt=%0d err=%b expected busy=%h cnt=%0d err=%b",
                             e.nm, busy_mask, pending_cnt, err_wb_idle, e.busy, e.cnt, e.err);
                end
            end
            if (e.chk_sc) begin
                n_checks++;
                if (stall_cycles !== e.sc) begin
                    n_fail++;
                    $display("FAIL %s stall_cycles: got %h expected %h", e.nm, stall_cycles, e.sc);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic [3:0] outs, input bit chk_st,
                       input logic [31:0] busy, input logic [3:0] cnt, input logic err,
                       input bit chk_sc = 1'b0, input logic [15:0] sc = 16'h0);
        exp_t e;
        e.nm = nm; e.outs = outs; e.chk_st = chk_st; e.busy = busy; e.cnt = cnt;
        e.err = err; e.chk_sc = chk_sc; e.sc = sc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic id_in(input logic v, input logic [4:0] rd, input logic wr,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic fence);
        id_valid = v; id_rd = rd; id_write_reg = wr;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2; id_fence = fence;
    endtask

    task automatic wb_in(input logic v, input logic [4:0] rd);
        wb_valid = v; wb_rd = rd;
    endtask

    initial begin
        rst = 1'b0; ex_ready = 1'b1; flush_req = 1'b0;
        id_in(0, 0, 0, 0, 0, 0, 0, 0);
        wb_in(0, 0);
        $display("bubble instruction 0x%08h", NOP_INSTR);
        @(posedge clk);
        #1;
        cyc("reset", 4'b0000, 1, 32'h0, 0, 0, 1, 16'h0);
        rst = 1'b1;

        // RAW on x5 held until its writeback retires
        id_in(1, 5, 1, 0, 0, 0, 0, 0);  cyc("raw_issue_x5",  4'b1000, 1, 32'h0, 0, 0);
        id_in(1, 0, 0, 5, 1, 0, 0, 0);  cyc("raw_stall_rs1", 4'b0110, 1, 32'h20, 1, 0);
        id_in(1, 0, 0, 0, 0, 5, 1, 0);
        wb_in(1, 5);                    cyc("raw_stall_wb",  4'b0110, 1, 32'h20, 1, 0);
        wb_in(0, 0);                    cyc("raw_release",   4'b1000, 1, 32'h0, 0, 0);

        // WAW on x7 with same-cycle retire, then issue+wb of different regs (net 0)
        id_in(1, 7, 1, 0, 0, 0, 0, 0);  cyc("waw_issue_x7",  4'b1000, 1, 32'h0, 0, 0);
        wb_in(1, 7);                    cyc("waw_stall_wb7", 4'b0110, 1, 32'h80, 1, 0);
        wb_in(0, 0);                    cyc("waw_reissue",   4'b1000, 1, 32'h0, 0, 0);
        id_in(1, 8, 1, 0, 0, 0, 0, 0);
        wb_in(1, 7);                    cyc("iss8_wb7",      4'b1000, 1, 32'h80, 1, 0);
        id_in(0, 0, 0, 0, 0, 0, 0, 0);
        wb_in(0, 0);                    cyc("net_zero",      4'b0010, 1, 32'h100, 1, 0);
        wb_in(1, 8);                    cyc("wb8",           4'b0010, 1, 32'h100, 1, 0);
        wb_in(0, 0);

        // Pending table full at MAX_PENDING=4
        id_in(1, 1, 1, 0, 0, 0, 0, 0);  cyc("full_iss1",     4'b1000, 1, 32'h0, 0, 0);
        id_rd = 2;                      cyc("full_iss2",     4'b1000, 1, 32'h2, 1, 0);
        id_rd = 3;                      cyc("full_iss3",     4'b1000, 1, 32'h6, 2, 0);
        id_rd = 4;                      cyc("full_iss4",     4'b1000, 1, 32'hE, 3, 0);
        id_rd = 6;                      cyc("full_stall",    4'b0110, 1, 32'h1E, 4, 0);
        wb_in(1, 1);                    cyc("full_stall_wb", 4'b0110, 1, 32'h1E, 4, 0);
        wb_in(0, 0);                    cyc("full_release",  4'b1000, 1, 32'h1C, 3, 0);
        id_in(0, 0, 0, 0, 0, 0, 0, 0);
        wb_in(1, 2);                    cyc("full_peak",     4'b0010, 1, 32'h5C, 4, 0);
        wb_in(1, 3);                    cyc("drain_q3",      4'b0010, 1, 32'h58, 3, 0);
        wb_in(1, 4);                    cyc("drain_q2",      4'b0010, 1, 32'h50, 2, 0);
        wb_in(1, 6);                    cyc("drain_q1",      4'b0010, 1, 32'h40, 1, 0);
        wb_in(0, 0);                    cyc("drain_q0",      4'b0010, 1, 32'h0, 0, 0);

        // Redirect: two flush cycles, then extended to three by a second request
        id_in(1, 10, 1, 0, 0, 0, 0, 0);
        flush_req = 1;                  cyc("flush_req",     4'b0110, 1, 32'h0, 0, 0);
        flush_req = 0;                  cyc("flush_c1",      4'b0011, 1, 32'h0, 0, 0);
                                        cyc("flush_c2",      4'b0011, 1, 32'h0, 0, 0);
                                        cyc("flush_done",    4'b1000, 1, 32'h0, 0, 0);
        id_in(0, 0, 0, 0, 0, 0, 0, 0);
        flush_req = 1;                  cyc("flush2_req",    4'b0010, 1, 32'h400, 1, 0);
                                        cyc("flush2_c1_req", 4'b0011, 1, 32'h400, 1, 0);
        flush_req = 0; wb_in(1, 10);    cyc("flush2_c2_wb",  4'b0011, 1, 32'h400, 1, 0);
        wb_in(0, 0);                    cyc("flush2_c3",     4'b0011, 1, 32'h0, 0, 0);
                                        cyc("flush2_done",   4'b0010, 1, 32'h0, 0, 0);

        // Fence drains two pending writes, then issues; idle writeback error
        id_in(1, 11, 1, 0, 0, 0, 0, 0); cyc("fence_pre11",   4'b1000, 1, 32'h0, 0, 0);
        id_rd = 12;                     cyc("fence_pre12",   4'b1000, 1, 32'h800, 1, 0);
        id_in(1, 0, 0, 0, 0, 0, 0, 1);  cyc("fence_enter",   4'b0110, 1, 32'h1800, 2, 0);
        wb_in(1, 11);                   cyc("drain_wb11",    4'b0110, 1, 32'h1800, 2, 0);
        wb_in(1, 12);                   cyc("drain_wb12",    4'b0110, 1, 32'h1000, 1, 0);
        wb_in(0, 0);                    cyc("fence_issue",   4'b1000, 1, 32'h0, 0, 0);
        id_in(0, 0, 0, 0, 0, 0, 0, 0);
        wb_in(1, 9);                    cyc("wb_idle_x9",    4'b0010, 1, 32'h0, 0, 0);
        wb_in(0, 0);                    cyc("err_set",       4'b0010, 1, 32'h0, 0, 1);
                                        cyc("err_sticky",    4'b0010, 1, 32'h0, 0, 1);

        // Redirect during drain discards the fence
        id_in(1, 0, 0, 0, 0, 0, 0, 1);  cyc("fence2_enter",  4'b0110, 1, 32'h0, 0, 1);
        flush_req = 1;                  cyc("drain_flush",   4'b0110, 1, 32'h0, 0, 1);
        flush_req = 0;
        id_in(0, 0, 0, 0, 0, 0, 0, 0);  cyc("dflush_c1",     4'b0011, 1, 32'h0, 0, 1);
                                        cyc("dflush_c2",     4'b0011, 1, 32'h0, 0, 1);
                                        cyc("dflush_run",    4'b0010, 1, 32'h0, 0, 1);

        // Reset in the middle of a drain
        id_in(1, 13, 1, 0, 0, 0, 0, 0); cyc("rst_pre13",     4'b1000, 1, 32'h0, 0, 1);
        id_in(1, 0, 0, 0, 0, 0, 0, 1);  cyc("rst_fence",     4'b0110, 1, 32'h2000, 1, 1);
                                        cyc("rst_draining",  4'b0110, 1, 32'h2000, 1, 1);
        rst = 0;                        cyc("rst_asserted",  4'b0000, 1, 32'h2000, 1, 1);
                                        cyc("rst_applied",   4'b0000, 1, 32'h0, 0, 0, 1, 16'h0);
        rst = 1;                        cyc("rst_run_fence", 4'b0110, 1, 32'h0, 0, 0, 1, 16'h0);
                                        cyc("rst_fence_iss", 4'b1000, 1, 32'h0, 0, 0, 1, 16'h1);

        // Back-pressure stall long enough to saturate the counter
        id_in(1, 0, 0, 0, 0, 0, 0, 0);
        ex_ready = 0;                   cyc("bp_stall",      4'b0110, 0, 32'h0, 0, 0, 1, 16'h1);
        repeat ((1 << 16) + 3) @(posedge clk);
        #1;
                                        cyc("sc_saturated",  4'b0110, 1, 32'h0, 0, 0, 1, 16'hFFFF);
        id_valid = 0;                   cyc("sc_hold",       4'b0010, 1, 32'h0, 0, 0, 1, 16'hFFFF);
                                        cyc("sc_hold2",      4'b0010, 0, 32'h0, 0, 0, 1, 16'hFFFF);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
